incoming_port_handler: RTL and testbench

Per-port ingress stage of the mesh router. Accepts packets arriving on one link (N, S, E or W), buffers them in a small FIFO, computes a dimension-ordered (X-then-Y) route for the head packet, and presents it to exactly one output port arbiter (or the local cache arbiter) via a one-hot select. The head is popped only when the chosen output signals ready, providing back-pressure to the upstream link.

---
 rtl/incoming_port_handler_pkg.sv | 64 ++++++
 rtl/incoming_port_handler_packet_fifo.sv | 57 +++++
 rtl/incoming_port_handler.sv | 143 ++++++++++++++
 tb/tb_incoming_port_handler.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/incoming_port_handler_pkg.sv
// ============================================================================
// Module      : incoming_port_handler_pkg
// Description : Mesh-router widths, coordinate field split, port IDs, packet
//               layout and the dimension-ordered (X-then-Y) route function.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package incoming_port_handler_pkg;

    localparam int NETWORK_ADDRESS_WIDTH    = 8;
    localparam int CACHE_BANK_ADDRESS_WIDTH = 4;
    localparam int DATA_WIDTH               = 32;
    localparam int DA_WIDTH                 = NETWORK_ADDRESS_WIDTH + CACHE_BANK_ADDRESS_WIDTH;
    localparam int COORD_WIDTH              = NETWORK_ADDRESS_WIDTH / 2;

    typedef enum logic [2:0] {
        PORT_NORTH = 3'd0,
        PORT_SOUTH = 3'd1,
        PORT_EAST  = 3'd2,
        PORT_WEST  = 3'd3,
        PORT_LOCAL = 3'd4
    } port_e;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ISSUE = 2'd1,
        ST_STALL = 2'd2
    } ihState_e;

    typedef struct packed {
        logic [DA_WIDTH-1:0]              destinationAddress;
        logic [NETWORK_ADDRESS_WIDTH-1:0] requesterAddress;
        logic                             read;
        logic                             write;
        logic [DATA_WIDTH-1:0]            data;
    } packet_t;

    // Network address occupies the upper bits of the destination as {X, Y}.
    function automatic logic [COORD_WIDTH-1:0] destX(input logic [DA_WIDTH-1:0] dest);
        return dest[DA_WIDTH-1 -: COORD_WIDTH];
    endfunction

    function automatic logic [COORD_WIDTH-1:0] destY(input logic [DA_WIDTH-1:0] dest);
        return dest[DA_WIDTH-COORD_WIDTH-1 -: COORD_WIDTH];
    endfunction

    function automatic port_e xyRoute(input logic [DA_WIDTH-1:0]    dest,
                                      input logic [COORD_WIDTH-1:0] localX,
                                      input logic [COORD_WIDTH-1:0] localY);
        logic [COORD_WIDTH-1:0] x;
        logic [COORD_WIDTH-1:0] y;
        x = destX(dest);
        y = destY(dest);
        if (x > localX) return PORT_EAST;
        if (x < localX) return PORT_WEST;
        if (y > localY) return PORT_NORTH;
        if (y < localY) return PORT_SOUTH;
        return PORT_LOCAL;
    endfunction

endpackage

`default_nettype wire

// File: rtl/incoming_port_handler_packet_fifo.sv
// ============================================================================
// Module      : packet_fifo
// Description : Power-of-two packet FIFO with occupancy count and full flag;
//               the head entry is always visible on headData.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module packet_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] pushData,
    input  logic             pop,
    output logic [WIDTH-1:0] headData,
    output logic             full,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wrPtr;
    logic [PTR_W-1:0] r_rdPtr;
    logic [CNT_W-1:0] r_count;

    // Pointers wrap for free because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (push) r_wrPtr <= r_wrPtr + PTR_W'(1);
            if (pop)  r_rdPtr <= r_rdPtr + PTR_W'(1);
            case ({push, pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) r_mem[r_wrPtr] <= pushData;
    end

    assign headData = r_mem[r_rdPtr];
    assign full     = (r_count == CNT_W'(DEPTH));
    assign count    = r_count;

endmodule

`default_nettype wire

// File: rtl/incoming_port_handler.sv
// ============================================================================
// Module      : incoming_port_handler
// Description : Per-link ingress stage: buffers packets, XY-routes the head to
//               one output arbiter via one-hot select, drops U-turn packets.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module incoming_port_handler
    import incoming_port_handler_pkg::*;
#(
    parameter int PORT_ID    = 0,
    parameter int LOCAL_X    = 0,
    parameter int LOCAL_Y    = 0,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [DA_WIDTH-1:0]              destinationAddressIn,
    input  logic [NETWORK_ADDRESS_WIDTH-1:0] requesterAddressIn,
    input  logic                             readIn,
    input  logic                             writeIn,
    input  logic [DATA_WIDTH-1:0]            dataIn,
    output logic                             inputReady,
    input  logic                             portReady_NORTH,
    input  logic                             portReady_SOUTH,
    input  logic                             portReady_EAST,
    input  logic                             portReady_WEST,
    input  logic                             portReady_LOCAL,
    output logic                             selectBit_NORTH,
    output logic                             selectBit_SOUTH,
    output logic                             selectBit_EAST,
    output logic                             selectBit_WEST,
    output logic                             selectBit_LOCAL,
    output logic [DA_WIDTH-1:0]              destinationAddressOut,
    output logic [NETWORK_ADDRESS_WIDTH-1:0] requesterAddressOut,
    output logic                             readOut,
    output logic                             writeOut,
    output logic [DATA_WIDTH-1:0]            dataOut,
    output logic                             routeError,
    output logic [$clog2(FIFO_DEPTH):0]      packetCount
);

    localparam int                     CNT_W    = $clog2(FIFO_DEPTH) + 1;
    localparam logic [COORD_WIDTH-1:0] c_localX = COORD_WIDTH'(LOCAL_X);
    localparam logic [COORD_WIDTH-1:0] c_localY = COORD_WIDTH'(LOCAL_Y);
    localparam logic [2:0]             c_portId = 3'(PORT_ID);

    ihState_e         r_state;
    ihState_e         w_stateNext;
    packet_t          w_inPkt;
    packet_t          w_headPkt;
    port_e            w_route;
    logic [4:0]       w_readyVec;
    logic [4:0]       w_select;
    logic [CNT_W-1:0] w_count;
    logic             w_full;
    logic             w_push;
    logic             w_pop;
    logic             w_headValid;
    logic             w_uturn;
    logic             w_portReady;

    assign w_inPkt = '{
        destinationAddress: destinationAddressIn,
        requesterAddress:   requesterAddressIn,
        read:               readIn,
        write:              writeIn,
        data:               dataIn
    };

    // A push is judged on inputReady alone, so a same-edge pop never frees a slot.
    assign inputReady = ~w_full & ~reset;
    assign w_push     = (readIn | writeIn) & inputReady;

    packet_fifo #(
        .WIDTH (($bits(packet_t))),
        .DEPTH (FIFO_DEPTH)
    ) u_packet_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (w_push),
        .pushData (w_inPkt),
        .pop      (w_pop),
        .headData (w_headPkt),
        .full     (w_full),
        .count    (w_count)
    );

    assign w_headValid = (r_state != ST_EMPTY);
    assign w_route     = xyRoute(w_headPkt.destinationAddress, c_localX, c_localY);
    assign w_uturn     = w_headValid & (w_route == c_portId);

    assign w_readyVec  = {portReady_LOCAL, portReady_WEST, portReady_EAST,
                          portReady_SOUTH, portReady_NORTH};
    assign w_portReady = w_readyVec[w_route];

    // U-turn heads leave without waiting for any output.
    assign w_pop    = w_headValid & (w_uturn | w_portReady);
    assign w_select = (w_headValid & ~w_uturn) ? (5'b00001 << w_route) : 5'b00000;

    assign selectBit_NORTH = w_select[PORT_NORTH];
    assign selectBit_SOUTH = w_select[PORT_SOUTH];
    assign selectBit_EAST  = w_select[PORT_EAST];
    assign selectBit_WEST  = w_select[PORT_WEST];
    assign selectBit_LOCAL = w_select[PORT_LOCAL];

    assign destinationAddressOut = w_headValid ? w_headPkt.destinationAddress : '0;
    assign requesterAddressOut   = w_headValid ? w_headPkt.requesterAddress   : '0;
    assign readOut               = w_headValid & w_headPkt.read;
    assign writeOut              = w_headValid & w_headPkt.write;
    assign dataOut               = w_headValid ? w_headPkt.data : '0;
    assign routeError            = w_uturn;
    assign packetCount           = w_count;

    always_ff @(posedge clk) begin
        if (reset) r_state <= ST_EMPTY;
        else       r_state <= w_stateNext;
    end

    // ISSUE marks a head just presented; STALL marks a head held over because
    // its output was not ready, so select and fields stay unchanged.
    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            ST_EMPTY: begin
                if (w_push) w_stateNext = ST_ISSUE;
            end
            ST_ISSUE, ST_STALL: begin
                if (!w_pop)
                    w_stateNext = ST_STALL;
                else if ((w_count == CNT_W'(1)) && !w_push)
                    w_stateNext = ST_EMPTY;
                else
                    w_stateNext = ST_ISSUE;
            end
            default: w_stateNext = ST_EMPTY;
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_incoming_port_handler.sv
// ============================================================================
// Module      : tb_incoming_port_handler
// Description : Self-checking bench for incoming_port_handler against a
//               queue-based packet model (router at (1,1), south-side link).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_incoming_port_handler;
    import incoming_port_handler_pkg::*;

    localparam int PID   = 1;
    localparam int LX    = 1;
    localparam int LY    = 1;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                             reset;
    logic [DA_WIDTH-1:0]              destIn;
    logic [NETWORK_ADDRESS_WIDTH-1:0] reqIn;
    logic                             rdIn;
    logic                             wrIn;
    logic [DATA_WIDTH-1:0]            dIn;
    logic [4:0]                       rdy;

    logic                             inputReady;
    logic                             selN, selS, selE, selW, selL;
    logic [DA_WIDTH-1:0]              destOut;
    logic [NETWORK_ADDRESS_WIDTH-1:0] reqOut;
    logic                             rdOut, wrOut;
    logic [DATA_WIDTH-1:0]            dOut;
    logic                             routeError;
    logic [CW-1:0]                    count;
    logic [4:0]                       selV;

    assign selV = {selL, selW, selE, selS, selN};

    incoming_port_handler #(
        .PORT_ID(PID), .LOCAL_X(LX), .LOCAL_Y(LY), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .reset(reset),
        .destinationAddressIn(destIn), .requesterAddressIn(reqIn),
        .readIn(rdIn), .writeIn(wrIn), .dataIn(dIn),
        .inputReady(inputReady),
        .portReady_NORTH(rdy[0]), .portReady_SOUTH(rdy[1]), .portReady_EAST(rdy[2]),
        .portReady_WEST(rdy[3]), .portReady_LOCAL(rdy[4]),
        .selectBit_NORTH(selN), .selectBit_SOUTH(selS), .selectBit_EAST(selE),
        .selectBit_WEST(selW), .selectBit_LOCAL(selL),
        .destinationAddressOut(destOut), .requesterAddressOut(reqOut),
        .readOut(rdOut), .writeOut(wrOut), .dataOut(dOut),
        .routeError(routeError), .packetCount(count)
    );

    typedef struct {
        logic [DA_WIDTH-1:0]              dest;
        logic [NETWORK_ADDRESS_WIDTH-1:0] req;
        logic                             rd;
        logic                             wr;
        logic [DATA_WIDTH-1:0]            data;
    } mpkt_t;

    mpkt_t q[$];
    int nChecks = 0;
    int nFails  = 0;

    // Reference route: 0=N 1=S 2=E 3=W 4=Local, X resolved before Y.
    function automatic int mRoute(input logic [DA_WIDTH-1:0] d);
        int x, y;
        x = int'(d[DA_WIDTH-1 -: COORD_WIDTH]);
        y = int'(d[DA_WIDTH-COORD_WIDTH-1 -: COORD_WIDTH]);
        if (x > LX) return 2;
        if (x < LX) return 3;
        if (y > LY) return 0;
        if (y < LY) return 1;
        return 4;
    endfunction

    function automatic logic [4:0] expSel();
        int r;
        if (q.size() == 0) return 5'b0;
        r = mRoute(q[0].dest);
        if (r == PID) return 5'b0;
        return 5'b00001 << r;
    endfunction

    function automatic logic expErr();
        if (q.size() == 0) return 1'b0;
        return mRoute(q[0].dest) == PID;
    endfunction

    function automatic logic [DA_WIDTH-1:0] mkDest(input int x, input int y);
        logic [CACHE_BANK_ADDRESS_WIDTH-1:0] b;
        b = CACHE_BANK_ADDRESS_WIDTH'($urandom_range(0, 15));
        return {COORD_WIDTH'(x), COORD_WIDTH'(y), b};
    endfunction

    task automatic drive(input logic r, input logic w, input logic [DA_WIDTH-1:0] d,
                         input logic [DATA_WIDTH-1:0] data);
        rdIn   = r;
        wrIn   = w;
        destIn = d;
        dIn    = data;
        reqIn  = NETWORK_ADDRESS_WIDTH'($urandom_range(0, 255));
    endtask

    task automatic idle();
        rdIn = 1'b0;
        wrIn = 1'b0;
    endtask

    // Advance one edge and apply the same edge to the model.
    task automatic tick();
        bit doPush, doPop;
        int r;
        @(posedge clk);
        if (reset) begin
            q.delete();
        end else begin
            doPush = (rdIn | wrIn) && (q.size() < DEPTH);
            doPop  = 1'b0;
            if (q.size() > 0) begin
                r     = mRoute(q[0].dest);
                doPop = (r == PID) || rdy[3'(r)];
            end
            if (doPop)  void'(q.pop_front());
            if (doPush) q.push_back('{destIn, reqIn, rdIn, wrIn, dIn});
        end
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle();
        destIn = '0; reqIn = '0; dIn = '0;
        rdy = 5'b0;
        tick();
        tick();
        nChecks++; if (inputReady !== 1'b0) begin nFails++; $display("FAIL reset_inputReady got %b want 0", inputReady); end
        nChecks++; if (count !== CW'(0)) begin nFails++; $display("FAIL reset_count got %0d want 0", count); end
        nChecks++; if (selV !== 5'b0) begin nFails++; $display("FAIL reset_select got %b want 00000", selV); end
        nChecks++; if ({rdOut, wrOut, routeError} !== 3'b0) begin nFails++; $display("FAIL reset_flags got %b want 000", {rdOut, wrOut, routeError}); end
        nChecks++; if ({destOut, reqOut, dOut} !== '0) begin nFails++; $display("FAIL reset_fields got %h want 0", {destOut, reqOut, dOut}); end
        reset = 1'b0;
        tick();
        nChecks++; if (inputReady !== 1'b1) begin nFails++; $display("FAIL post_reset_inputReady got %b want 1", inputReady); end
    endtask

    task automatic test_local();
        rdy = 5'b10000;
        drive(1'b0, 1'b1, mkDest(1, 1), 32'hC0DE_0001);
        tick();
        idle();
        nChecks++; if (selV !== 5'b10000) begin nFails++; $display("FAIL local_select got %b want 10000", selV); end
        nChecks++; if ({rdOut, wrOut} !== 2'b01) begin nFails++; $display("FAIL local_type got %b want 01", {rdOut, wrOut}); end
        nChecks++; if (dOut !== 32'hC0DE_0001) begin nFails++; $display("FAIL local_data got %h want c0de0001", dOut); end
        tick();
        nChecks++; if (count !== CW'(0)) begin nFails++; $display("FAIL local_drain got %0d want 0", count); end
        nChecks++; if (selV !== 5'b0) begin nFails++; $display("FAIL local_select_clear got %b want 00000", selV); end
    endtask

    task automatic test_xy_order();
        rdy = 5'b11111;
        drive(1'b0, 1'b1, mkDest(3, 0), 32'h0000_0E01);
        tick();
        nChecks++; if (selV !== 5'b00100) begin nFails++; $display("FAIL xy_first_east got %b want 00100", selV); end
        nChecks++; if (dOut !== 32'h0000_0E01) begin nFails++; $display("FAIL xy_first_data got %h want 00000e01", dOut); end
        drive(1'b1, 1'b0, mkDest(1, 3), 32'h0000_0A02);
        tick();
        idle();
        nChecks++; if (selV !== 5'b00001) begin nFails++; $display("FAIL xy_second_north got %b want 00001", selV); end
        nChecks++; if ({dOut, rdOut} !== {32'h0000_0A02, 1'b1}) begin nFails++; $display("FAIL xy_second_data got %h want 00000a02", dOut); end
        nChecks++; if (count !== CW'(1)) begin nFails++; $display("FAIL xy_count got %0d want 1", count); end
        tick();
    endtask

    task automatic test_back_pressure();
        rdy = 5'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b1, mkDest(3, i), 32'hA0 + i);
            tick();
        end
        nChecks++; if (count !== CW'(4)) begin nFails++; $display("FAIL bp_count_full got %0d want 4", count); end
        nChecks++; if (inputReady !== 1'b0) begin nFails++; $display("FAIL bp_inputReady got %b want 0", inputReady); end
        drive(1'b0, 1'b1, mkDest(3, 0), 32'hBAD);
        tick();
        idle();
        nChecks++; if (count !== CW'(4)) begin nFails++; $display("FAIL bp_fifth_ignored got %0d want 4", count); end
        nChecks++; if ({selV, dOut} !== {5'b00100, 32'hA0}) begin nFails++; $display("FAIL bp_stall_stable got %b/%h want 00100/a0", selV, dOut); end
        rdy[2] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            nChecks++; if (dOut !== 32'hA0 + i) begin nFails++; $display("FAIL bp_order got %h want %h", dOut, 32'hA0 + i); end
            tick();
            nChecks++; if (count !== CW'(3 - i)) begin nFails++; $display("FAIL bp_drain_count got %0d want %0d", count, 3 - i); end
        end
    endtask

    task automatic test_back_to_back();
        rdy = 5'b0;
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 1'b1, mkDest(1, 3), 32'h500 + i);
            tick();
        end
        nChecks++; if (count !== CW'(2)) begin nFails++; $display("FAIL b2b_prefill got %0d want 2", count); end
        rdy[0] = 1'b1;
        for (int i = 0; i < 10; i++) begin
            nChecks++; if (dOut !== 32'h500 + i) begin nFails++; $display("FAIL b2b_head got %h want %h", dOut, 32'h500 + i); end
            drive(1'b1, 1'b0, mkDest(1, 3), 32'h502 + i);
            tick();
            nChecks++; if (count !== CW'(2)) begin nFails++; $display("FAIL b2b_count got %0d want 2", count); end
        end
        idle();
        tick();
        tick();
        nChecks++; if (count !== CW'(0)) begin nFails++; $display("FAIL b2b_drain got %0d want 0", count); end
    endtask

    task automatic test_uturn();
        rdy = 5'b0;
        drive(1'b0, 1'b1, mkDest(1, 0), 32'hDEAD_0001);
        tick();
        idle();
        nChecks++; if (selV !== 5'b0) begin nFails++; $display("FAIL uturn_select got %b want 00000", selV); end
        nChecks++; if (routeError !== 1'b1) begin nFails++; $display("FAIL uturn_error got %b want 1", routeError); end
        tick();
        nChecks++; if (count !== CW'(0)) begin nFails++; $display("FAIL uturn_dropped got %0d want 0", count); end
        nChecks++; if (routeError !== 1'b0) begin nFails++; $display("FAIL uturn_pulse got %b want 0", routeError); end
    endtask

    task automatic test_mid_reset();
        rdy = 5'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1, mkDest(0, 2), 32'h700 + i);
            tick();
        end
        idle();
        nChecks++; if (count !== CW'(3)) begin nFails++; $display("FAIL mr_queued got %0d want 3", count); end
        reset = 1'b1;
        tick();
        nChecks++; if (count !== CW'(0)) begin nFails++; $display("FAIL mr_count got %0d want 0", count); end
        nChecks++; if (selV !== 5'b0) begin nFails++; $display("FAIL mr_select got %b want 00000", selV); end
        nChecks++; if (inputReady !== 1'b0) begin nFails++; $display("FAIL mr_inputReady got %b want 0", inputReady); end
        reset = 1'b0;
        tick();
        nChecks++; if (inputReady !== 1'b1) begin nFails++; $display("FAIL mr_recover got %b want 1", inputReady); end
    endtask

    task automatic test_random();
        logic [DA_WIDTH-1:0]              eDest;
        logic [NETWORK_ADDRESS_WIDTH-1:0] eReq;
        logic [DATA_WIDTH-1:0]            eData;
        logic [1:0]                       eType;
        for (int n = 0; n < 400; n++) begin
            eDest = '0; eReq = '0; eData = '0; eType = 2'b00;
            if (q.size() > 0) begin
                eDest = q[0].dest; eReq = q[0].req; eData = q[0].data; eType = {q[0].rd, q[0].wr};
            end
            nChecks++; if (count !== CW'(q.size())) begin nFails++; $display("FAIL rnd_count cyc %0d got %0d want %0d", n, count, q.size()); end
            nChecks++; if (selV !== expSel()) begin nFails++; $display("FAIL rnd_select cyc %0d got %b want %b", n, selV, expSel()); end
            nChecks++; if (routeError !== expErr()) begin nFails++; $display("FAIL rnd_routeError cyc %0d got %b want %b", n, routeError, expErr()); end
            nChecks++; if (inputReady !== (!reset && q.size() < DEPTH)) begin nFails++; $display("FAIL rnd_inputReady cyc %0d got %b", n, inputReady); end
            nChecks++; if ({destOut, reqOut, dOut, rdOut, wrOut} !== {eDest, eReq, eData, eType}) begin
                nFails++; $display("FAIL rnd_fields cyc %0d got %h/%h/%h want %h/%h/%h", n, destOut, reqOut, dOut, eDest, eReq, eData);
            end
            reset = ($urandom_range(0, 99) < 2);
            rdy   = 5'($urandom_range(0, 31));
            if ($urandom_range(0, 9) < 6) begin
                if ($urandom_range(0, 1) == 1) drive(1'b1, 1'b0, mkDest($urandom_range(0, 3), $urandom_range(0, 3)), $urandom);
                else                           drive(1'b0, 1'b1, mkDest($urandom_range(0, 3), $urandom_range(0, 3)), $urandom);
            end else begin
                idle();
            end
            tick();
        end
        reset = 1'b0;
        idle();
    endtask

    initial begin
        test_reset();
        test_local();
        test_xy_order();
        test_back_pressure();
        test_back_to_back();
        test_uturn();
        test_mid_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule

`default_nettype wire
